// File: rtl/dvi_pkg.sv
// Shared types and TMDS control-token constants for the DVI lane sequencer and encoder path.
package dvi_pkg;

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_LOCK_WAIT = 2'd1,
    ST_FLUSH     = 2'd2,
    ST_RUN       = 2'd3
  } dvi_state_e;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  // Maps {c1,c0} to the TMDS control-period word.
  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] tok;
    case (c)
      2'b00:   tok = CTRL_TOKEN_00;
      2'b01:   tok = CTRL_TOKEN_01;
      2'b10:   tok = CTRL_TOKEN_10;
      default: tok = CTRL_TOKEN_11;
    endcase
    return tok;
  endfunction

endpackage

// File: rtl/dvi_blank_gen.sv
// Combinational blanking word set: lane 0 carries the sync token, lanes 1 and 2 carry token 00.
module dvi_blank_gen
  import dvi_pkg::*;
(
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] lane0,
  output logic [9:0] lane1,
  output logic [9:0] lane2
);

  assign lane0 = ctrl_token({vsync, hsync});
  assign lane1 = CTRL_TOKEN_00;
  assign lane2 = CTRL_TOKEN_00;

endmodule

// File: rtl/dvi_lane_sequencer.sv
// Start-up/runtime sequencer for the three TMDS serializer lanes (PLL lock wait, flush, run).
// Optional status counters are built when DVI_SEQ_STATUS_EN is defined.
module dvi_lane_sequencer
  import dvi_pkg::*;
#(
  parameter int unsigned LOCK_STABLE = 1024,
  parameter int unsigned FLUSH_WORDS = 128
) (
  input  logic        ref_clk_i,
  input  logic        rst,
  input  logic        pll_lock_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        enc_valid_i,
  input  logic [9:0]  enc_ch0_i,
  input  logic [9:0]  enc_ch1_i,
  input  logic [9:0]  enc_ch2_i,
  output logic        enc_ready_o,
  output logic        ser_rst_o,
  output logic [9:0]  ch0_o,
  output logic [9:0]  ch1_o,
  output logic [9:0]  ch2_o,
  output logic [1:0]  state_o,
  output logic        underrun_o
`ifdef DVI_SEQ_STATUS_EN
  ,
  output logic [15:0] underrun_cnt_o,
  output logic [7:0]  relock_cnt_o
`endif
);

  localparam logic [15:0] LOCK_LAST  = 16'(LOCK_STABLE - 1);
  localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_WORDS - 1);

  dvi_state_e  state, state_next;
  logic [15:0] cnt, cnt_next;
  logic [9:0]  blank0, blank1, blank2;
  logic [9:0]  ch0_d, ch1_d, ch2_d;
  logic        ser_rst_d, enc_ready_d, underrun_hit;

  dvi_blank_gen u_blank_gen (
    .hsync (hsync_i),
    .vsync (vsync_i),
    .lane0 (blank0),
    .lane1 (blank1),
    .lane2 (blank2)
  );

  always_ff @(posedge ref_clk_i or posedge rst) begin
    if (rst) begin
      state <= ST_RESET;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Lock loss is tested first so it wins over the FLUSH->RUN step.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_RESET: begin
        state_next = ST_LOCK_WAIT;
        cnt_next   = '0;
      end
      ST_LOCK_WAIT: begin
        if (!pll_lock_i) begin
          cnt_next = '0;
        end else if (cnt == LOCK_LAST) begin
          state_next = ST_FLUSH;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      ST_FLUSH: begin
        if (!pll_lock_i) begin
          state_next = ST_LOCK_WAIT;
          cnt_next   = '0;
        end else if (cnt == FLUSH_LAST) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      ST_RUN: begin
        if (!pll_lock_i) begin
          state_next = ST_LOCK_WAIT;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = ST_RESET;
        cnt_next   = '0;
      end
    endcase
  end

  // Control outputs are registered from the next state so they line up with state_o;
  // lane words are registered from the current state so a word accepted while
  // enc_ready_o is high appears right after the edge that consumed it.
  always_comb begin
    ser_rst_d    = (state_next == ST_RESET) || (state_next == ST_LOCK_WAIT);
    enc_ready_d  = (state_next == ST_RUN);
    underrun_hit = (state == ST_RUN) && !enc_valid_i;
    ch0_d        = blank0;
    ch1_d        = blank1;
    ch2_d        = blank2;
    if (state == ST_RESET) begin
      ch0_d = CTRL_TOKEN_00;
      ch1_d = CTRL_TOKEN_00;
      ch2_d = CTRL_TOKEN_00;
    end else if ((state == ST_RUN) && enc_valid_i) begin
      ch0_d = enc_ch0_i;
      ch1_d = enc_ch1_i;
      ch2_d = enc_ch2_i;
    end
  end

  always_ff @(posedge ref_clk_i or posedge rst) begin
    if (rst) begin
      ser_rst_o   <= 1'b1;
      enc_ready_o <= 1'b0;
      ch0_o       <= CTRL_TOKEN_00;
      ch1_o       <= CTRL_TOKEN_00;
      ch2_o       <= CTRL_TOKEN_00;
      underrun_o  <= 1'b0;
    end else begin
      ser_rst_o   <= ser_rst_d;
      enc_ready_o <= enc_ready_d;
      ch0_o       <= ch0_d;
      ch1_o       <= ch1_d;
      ch2_o       <= ch2_d;
      if (underrun_hit) underrun_o <= 1'b1;
    end
  end

  assign state_o = state;

`ifdef DVI_SEQ_STATUS_EN
  logic relock_hit;

  assign relock_hit = ((state == ST_FLUSH) || (state == ST_RUN)) &&
                      (state_next == ST_LOCK_WAIT);

  // Both counters saturate instead of wrapping so a long-running fault stays visible.
  always_ff @(posedge ref_clk_i or posedge rst) begin
    if (rst) begin
      underrun_cnt_o <= '0;
      relock_cnt_o   <= '0;
    end else begin
      if (underrun_hit && (underrun_cnt_o != 16'hFFFF))
        underrun_cnt_o <= underrun_cnt_o + 16'd1;
      if (relock_hit && (relock_cnt_o != 8'hFF))
        relock_cnt_o <= relock_cnt_o + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dvi_lane_sequencer.sv
// Directed self-checking bench for dvi_lane_sequencer (default LOCK_STABLE=1024, FLUSH_WORDS=128).
module tb_dvi_lane_sequencer;

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam int LS = 1024;
  localparam int FW = 128;
  localparam int BOUND = 5000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock = 1'b1;
  logic       hsync = 1'b0;
  logic       vsync = 1'b0;
  logic       enc_valid = 1'b0;
  logic [9:0] enc_ch0 = '0;
  logic [9:0] enc_ch1 = '0;
  logic [9:0] enc_ch2 = '0;
  logic       enc_ready_o, ser_rst_o, underrun_o;
  logic [9:0] ch0_o, ch1_o, ch2_o;
  logic [1:0] state_o;
`ifdef DVI_SEQ_STATUS_EN
  logic [15:0] underrun_cnt_o;
  logic [7:0]  relock_cnt_o;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  dvi_lane_sequencer #(.LOCK_STABLE(LS), .FLUSH_WORDS(FW)) dut (
    .ref_clk_i   (clk),
    .rst         (rst),
    .pll_lock_i  (pll_lock),
    .hsync_i     (hsync),
    .vsync_i     (vsync),
    .enc_valid_i (enc_valid),
    .enc_ch0_i   (enc_ch0),
    .enc_ch1_i   (enc_ch1),
    .enc_ch2_i   (enc_ch2),
    .enc_ready_o (enc_ready_o),
    .ser_rst_o   (ser_rst_o),
    .ch0_o       (ch0_o),
    .ch1_o       (ch1_o),
    .ch2_o       (ch2_o),
    .state_o     (state_o),
    .underrun_o  (underrun_o)
`ifdef DVI_SEQ_STATUS_EN
    ,
    .underrun_cnt_o (underrun_cnt_o),
    .relock_cnt_o   (relock_cnt_o)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pll_lock = 1'b1;
    tick();
    tick();
    tests_run++; if (state_o !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    tests_run++; if (ser_rst_o !== 1'b1) begin tests_failed++; $display("FAIL reset_ser_rst: got %b expected 1", ser_rst_o); end
    tests_run++; if (enc_ready_o !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b expected 0", enc_ready_o); end
    tests_run++; if (underrun_o !== 1'b0) begin tests_failed++; $display("FAIL reset_underrun: got %b expected 0", underrun_o); end
    tests_run++; if ({ch0_o, ch1_o, ch2_o} !== {TOK_00, TOK_00, TOK_00}) begin tests_failed++; $display("FAIL reset_lanes: got %b %b %b expected %b x3", ch0_o, ch1_o, ch2_o, TOK_00); end
  endtask

  // Release reset with lock held; measure ser_rst and FLUSH lengths.
  task automatic test_startup();
    int n;
    hsync = 1'b0;
    vsync = 1'b1;
    enc_valid = 1'b1;
    enc_ch0 = 10'h001; enc_ch1 = 10'h002; enc_ch2 = 10'h003;
    rst = 1'b0;
    n = 0;
    while (ser_rst_o === 1'b1 && n < BOUND) begin n++; tick(); end
    tests_run++; if (n !== LS + 1) begin tests_failed++; $display("FAIL startup_ser_rst_cycles: got %0d expected %0d", n, LS + 1); end
    tests_run++; if (state_o !== 2'd2) begin tests_failed++; $display("FAIL startup_flush_entry: got %0d expected 2", state_o); end
    tests_run++; if (enc_ready_o !== 1'b0) begin tests_failed++; $display("FAIL startup_flush_ready: got %b expected 0", enc_ready_o); end
    tests_run++; if ({ch0_o, ch1_o, ch2_o} !== {TOK_10, TOK_00, TOK_00}) begin tests_failed++; $display("FAIL startup_blank_lanes: got %b %b %b expected %b %b %b", ch0_o, ch1_o, ch2_o, TOK_10, TOK_00, TOK_00); end
    n = 0;
    while (state_o === 2'd2 && n < BOUND) begin n++; tick(); end
    tests_run++; if (n !== FW) begin tests_failed++; $display("FAIL startup_flush_cycles: got %0d expected %0d", n, FW); end
    tests_run++; if (state_o !== 2'd3) begin tests_failed++; $display("FAIL startup_run_state: got %0d expected 3", state_o); end
    tests_run++; if (enc_ready_o !== 1'b1) begin tests_failed++; $display("FAIL startup_run_ready: got %b expected 1", enc_ready_o); end
    tests_run++; if (ser_rst_o !== 1'b0) begin tests_failed++; $display("FAIL startup_run_ser_rst: got %b expected 0", ser_rst_o); end
    tick();
    tests_run++; if ({ch0_o, ch1_o, ch2_o} !== {10'h001, 10'h002, 10'h003}) begin tests_failed++; $display("FAIL startup_first_word: got %h %h %h expected 001 002 003", ch0_o, ch1_o, ch2_o); end
    tests_run++; if (underrun_o !== 1'b0) begin tests_failed++; $display("FAIL startup_no_underrun: got %b expected 0", underrun_o); end
  endtask

  task automatic test_passthrough();
    logic [29:0] vec [3];
    vec[0] = {10'h155, 10'h2AA, 10'h0F0};
    vec[1] = {10'h3FF, 10'h000, 10'h1C3};
    vec[2] = {10'h0A5, 10'h35A, 10'h200};
    enc_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      {enc_ch0, enc_ch1, enc_ch2} = vec[i];
      tick();
      tests_run++; if ({ch0_o, ch1_o, ch2_o} !== vec[i]) begin tests_failed++; $display("FAIL passthrough_%0d: got %h %h %h expected %h %h %h", i, ch0_o, ch1_o, ch2_o, vec[i][29:20], vec[i][19:10], vec[i][9:0]); end
    end
  endtask

  task automatic test_underrun();
    hsync = 1'b1;
    vsync = 1'b0;
    enc_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if ({ch0_o, ch1_o, ch2_o} !== {TOK_01, TOK_00, TOK_00}) begin tests_failed++; $display("FAIL underrun_lanes_%0d: got %b %b %b expected %b %b %b", i, ch0_o, ch1_o, ch2_o, TOK_01, TOK_00, TOK_00); end
      tests_run++; if (underrun_o !== 1'b1) begin tests_failed++; $display("FAIL underrun_flag_%0d: got %b expected 1", i, underrun_o); end
    end
    enc_valid = 1'b1;
    enc_ch0 = 10'h111; enc_ch1 = 10'h222; enc_ch2 = 10'h333;
    tick();
    tests_run++; if ({ch0_o, ch1_o, ch2_o} !== {10'h111, 10'h222, 10'h333}) begin tests_failed++; $display("FAIL underrun_resume: got %h %h %h expected 111 222 333", ch0_o, ch1_o, ch2_o); end
    tests_run++; if (underrun_o !== 1'b1) begin tests_failed++; $display("FAIL underrun_sticky: got %b expected 1", underrun_o); end
`ifdef DVI_SEQ_STATUS_EN
    tests_run++; if (underrun_cnt_o !== 16'd3) begin tests_failed++; $display("FAIL underrun_count: got %0d expected 3", underrun_cnt_o); end
`endif
  endtask

  task automatic test_lock_loss();
    int n;
    pll_lock = 1'b0;
    tick();
    tests_run++; if (state_o !== 2'd1) begin tests_failed++; $display("FAIL lockloss_state: got %0d expected 1", state_o); end
    tests_run++; if (ser_rst_o !== 1'b1) begin tests_failed++; $display("FAIL lockloss_ser_rst: got %b expected 1", ser_rst_o); end
    tests_run++; if (enc_ready_o !== 1'b0) begin tests_failed++; $display("FAIL lockloss_ready: got %b expected 0", enc_ready_o); end
    tick();
    pll_lock = 1'b1;
    n = 0;
    while (state_o === 2'd1 && n < BOUND) begin n++; tick(); end
    tests_run++; if (n !== LS) begin tests_failed++; $display("FAIL lockloss_relock_cycles: got %0d expected %0d", n, LS); end
    n = 0;
    while (state_o === 2'd2 && n < BOUND) begin n++; tick(); end
    tests_run++; if (n !== FW) begin tests_failed++; $display("FAIL lockloss_reflush_cycles: got %0d expected %0d", n, FW); end
    tests_run++; if (state_o !== 2'd3) begin tests_failed++; $display("FAIL lockloss_back_in_run: got %0d expected 3", state_o); end
`ifdef DVI_SEQ_STATUS_EN
    tests_run++; if (relock_cnt_o !== 8'd1) begin tests_failed++; $display("FAIL lockloss_relock_count: got %0d expected 1", relock_cnt_o); end
`endif
  endtask

  // One-cycle lock glitch at count 500 must restart the full LOCK_STABLE window.
  task automatic test_lock_glitch();
    int n;
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    for (int i = 0; i < 500; i++) tick();
    tests_run++; if (state_o !== 2'd1) begin tests_failed++; $display("FAIL glitch_still_waiting: got %0d expected 1", state_o); end
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    n = 0;
    while (state_o === 2'd1 && n < BOUND) begin n++; tick(); end
    tests_run++; if (n !== LS) begin tests_failed++; $display("FAIL glitch_restart_cycles: got %0d expected %0d", n, LS); end
    n = 0;
    while (state_o === 2'd2 && n < BOUND) begin n++; tick(); end
    tests_run++; if (state_o !== 2'd3) begin tests_failed++; $display("FAIL glitch_run_state: got %0d expected 3", state_o); end
`ifdef DVI_SEQ_STATUS_EN
    tests_run++; if (relock_cnt_o !== 8'd2) begin tests_failed++; $display("FAIL glitch_relock_count: got %0d expected 2", relock_cnt_o); end
`endif
  endtask

  task automatic test_async_reset();
    enc_valid = 1'b1;
    enc_ch0 = 10'h0AA; enc_ch1 = 10'h0BB; enc_ch2 = 10'h0CC;
    tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++; if (state_o !== 2'd0) begin tests_failed++; $display("FAIL async_state: got %0d expected 0", state_o); end
    tests_run++; if (ser_rst_o !== 1'b1) begin tests_failed++; $display("FAIL async_ser_rst: got %b expected 1", ser_rst_o); end
    tests_run++; if (enc_ready_o !== 1'b0) begin tests_failed++; $display("FAIL async_ready: got %b expected 0", enc_ready_o); end
    tests_run++; if (underrun_o !== 1'b0) begin tests_failed++; $display("FAIL async_underrun: got %b expected 0", underrun_o); end
    tests_run++; if ({ch0_o, ch1_o, ch2_o} !== {TOK_00, TOK_00, TOK_00}) begin tests_failed++; $display("FAIL async_lanes: got %b %b %b expected %b x3", ch0_o, ch1_o, ch2_o, TOK_00); end
`ifdef DVI_SEQ_STATUS_EN
    tests_run++; if ({underrun_cnt_o, relock_cnt_o} !== 24'd0) begin tests_failed++; $display("FAIL async_counters: got %0d %0d expected 0 0", underrun_cnt_o, relock_cnt_o); end
`endif
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_startup();
    test_passthrough();
    test_underrun();
    test_lock_loss();
    test_lock_glitch();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
